// File: rtl/raster_setup_if.sv
// raster_setup_if: vertex-stage inputs and rasterizer-facing setup outputs of raster_setup
interface raster_setup_if;
    logic        vtx_valid;
    logic [19:0] x_v0, x_v1, x_v2, x_v3;
    logic [19:0] y_v0, y_v1, y_v2, y_v3;
    logic [21:0] inv_area_t1, inv_area_t2;
    logic        busy;
    logic [19:0] y_screen_v0, y_screen_v1, y_screen_v2, y_screen_v3;
    logic [19:0] e0_init_t1, e1_init_t1, e2_init_t1;
    logic [19:0] e0_init_t2, e1_init_t2, e2_init_t2;
    logic [21:0] bar_iy, bar_iz, bar_iy_dx, bar_iz_dx;
    logic [21:0] bar2_iy, bar2_iz, bar2_iy_dx, bar2_iz_dx;
    modport master (
        input  vtx_valid, x_v0, x_v1, x_v2, x_v3, y_v0, y_v1, y_v2, y_v3, inv_area_t1, inv_area_t2,
        output busy, y_screen_v0, y_screen_v1, y_screen_v2, y_screen_v3,
        output e0_init_t1, e1_init_t1, e2_init_t1, e0_init_t2, e1_init_t2, e2_init_t2,
        output bar_iy, bar_iz, bar_iy_dx, bar_iz_dx, bar2_iy, bar2_iz, bar2_iy_dx, bar2_iz_dx
    );
    modport slave (
        output vtx_valid, x_v0, x_v1, x_v2, x_v3, y_v0, y_v1, y_v2, y_v3, inv_area_t1, inv_area_t2,
        input  busy, y_screen_v0, y_screen_v1, y_screen_v2, y_screen_v3,
        input  e0_init_t1, e1_init_t1, e2_init_t1, e0_init_t2, e1_init_t2, e2_init_t2,
        input  bar_iy, bar_iz, bar_iy_dx, bar_iz_dx, bar2_iy, bar2_iz, bar2_iy_dx, bar2_iz_dx
    );
endinterface

// File: rtl/raster_setup.sv
// raster_setup: per-frame edge/barycentric setup for two triangles on one serial multiplier, stepped per line
module raster_setup #(
    parameter int MUL_W    = 22,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    raster_setup_if.master bus
);
    typedef enum logic [1:0] {IDLE, SNAP, MUL, DONE} state_t;
    state_t state, state_n;
    logic [19:0] sx [4];
    logic [19:0] sy [4];
    logic [21:0] sia [2];
    logic [19:0] ea [2][3];
    logic [19:0] eb [2][3];
    logic [19:0] fe [2][3];
    logic [21:0] f_iy [2];
    logic [21:0] f_iz [2];
    logic [21:0] f_iy_dx [2];
    logic [21:0] f_iz_dx [2];
    logic [21:0] f_iy_dy [2];
    logic [21:0] f_iz_dy [2];
    logic [19:0] e_out [2][3];
    logic [19:0] sb [2][3];
    logic [21:0] biy [2];
    logic [21:0] biz [2];
    logic [21:0] bdy [2];
    logic [21:0] bdz [2];
    logic [21:0] s_iy_dy [2];
    logic [21:0] s_iz_dy [2];
    logic [19:0] y_scr [4];
    logic pending, start, commit, step;
    logic [4:0] job, cnt;
    logic [19:0] tmp, pa, pv;
    logic [MUL_W-1:0] ma, mb, acc, acc_n, opa, opb;
    logic [21:0] prod;
    logic et, mt;
    logic [1:0] ek, vk, ik;

    assign start  = y == 10'(V_ACTIVE) && x == 10'd0;
    assign commit = y == 10'(V_TOTAL - 1) && x == 10'(H_TOTAL - 2);
    assign step   = y < 10'(V_ACTIVE) && x == 10'(H_ACTIVE);

    // t1 = (v0,v1,v2), t2 = (v0,v2,v3); edge k runs from local vertex k to k+1
    for (genvar t = 0; t < 2; t++) begin : g_tri
        for (genvar k = 0; k < 3; k++) begin : g_edge
            localparam int I = (t == 1 && k != 0) ? k + 1 : k;
            localparam int J = (t == 1 && (k + 1) % 3 != 0) ? (k + 1) % 3 + 1 : (k + 1) % 3;
            assign ea[t][k] = sy[J] - sy[I];
            assign eb[t][k] = sx[I] - sx[J];
        end
    end

    // jobs 0-11: a*x then b*y per edge; 12-19: a2,a0,b2,b0 times inv_area; 20-23: e2,e0 times inv_area
    assign et = job >= 5'd6;
    assign ek = 2'((job - (et ? 5'd6 : 5'd0)) >> 1);
    assign vk = (et && ek != 2'd0) ? ek + 2'd1 : ek;
    assign mt = job >= 5'd22 || (job >= 5'd16 && job < 5'd20);
    assign ik = job[0] ? 2'd0 : 2'd2;
    assign pa = job < 5'd12 ? (job[0] ? eb[et][ek] : ea[et][ek])
              : job < 5'd20 ? (job[1] ? eb[mt][ik] : ea[mt][ik])
              : fe[mt][ik];
    assign pv = job[0] ? sy[vk] : sx[vk];
    assign opa = MUL_W'($signed(pa));
    assign opb = job < 5'd12 ? MUL_W'($signed(pv)) : MUL_W'($signed(sia[mt]));
    assign acc_n = acc + (mb[0] ? ma : '0);
    assign prod = acc_n[21:0];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start && bus.vtx_valid ? SNAP : IDLE;
            SNAP:    state_n = MUL;
            MUL:     state_n = job == 5'd23 && cnt == 5'(MUL_W) ? DONE : MUL;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy = state == SNAP || state == MUL;

    // low product bits are sign-independent, so a plain unsigned shift-add suffices
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sx <= '{default: '0};
            sy <= '{default: '0};
            sia <= '{default: '0};
            fe <= '{default: '0};
            f_iy <= '{default: '0};
            f_iz <= '{default: '0};
            f_iy_dx <= '{default: '0};
            f_iz_dx <= '{default: '0};
            f_iy_dy <= '{default: '0};
            f_iz_dy <= '{default: '0};
            job <= '0;
            cnt <= '0;
            tmp <= '0;
            ma <= '0;
            mb <= '0;
            acc <= '0;
        end else if (state == SNAP) begin
            sx <= '{bus.x_v0, bus.x_v1, bus.x_v2, bus.x_v3};
            sy <= '{bus.y_v0, bus.y_v1, bus.y_v2, bus.y_v3};
            sia <= '{bus.inv_area_t1, bus.inv_area_t2};
            job <= '0;
            cnt <= '0;
        end else if (state == MUL) begin
            if (cnt == 5'd0) begin
                ma <= opa;
                mb <= opb;
                acc <= '0;
                cnt <= 5'd1;
            end else begin
                acc <= acc_n;
                ma <= ma << 1;
                mb <= mb >> 1;
                cnt <= cnt == 5'(MUL_W) ? 5'd0 : cnt + 5'd1;
                if (cnt == 5'(MUL_W)) begin
                    job <= job + 5'd1;
                    if (job < 5'd12) begin
                        if (!job[0]) tmp <= prod[19:0];
                        else fe[et][ek] <= -(tmp + prod[19:0]);
                    end else if (job < 5'd20) begin
                        if (job[1:0] == 2'd0) f_iy_dx[mt] <= prod;
                        if (job[1:0] == 2'd1) f_iz_dx[mt] <= prod;
                        if (job[1:0] == 2'd2) f_iy_dy[mt] <= prod;
                        if (job[1:0] == 2'd3) f_iz_dy[mt] <= prod;
                    end else if (job[0]) f_iz[mt] <= prod;
                    else f_iy[mt] <= prod;
                end
            end
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pending <= 1'b0;
        else if (state == DONE) pending <= 1'b1;
        else if (commit) pending <= 1'b0;

    // line-0 values always reload at commit so every frame restarts from the top
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            e_out <= '{default: '0};
            sb <= '{default: '0};
            biy <= '{default: '0};
            biz <= '{default: '0};
            bdy <= '{default: '0};
            bdz <= '{default: '0};
            s_iy_dy <= '{default: '0};
            s_iz_dy <= '{default: '0};
            y_scr <= '{default: '0};
        end else if (commit) begin
            e_out <= fe;
            biy <= f_iy;
            biz <= f_iz;
            if (pending) begin
                bdy <= f_iy_dx;
                bdz <= f_iz_dx;
                s_iy_dy <= f_iy_dy;
                s_iz_dy <= f_iz_dy;
                sb <= eb;
                y_scr <= sy;
            end
        end else if (step) begin
            for (int t = 0; t < 2; t++) begin
                for (int k = 0; k < 3; k++) e_out[t][k] <= e_out[t][k] + sb[t][k];
                biy[t] <= biy[t] + s_iy_dy[t];
                biz[t] <= biz[t] + s_iz_dy[t];
            end
        end

    assign bus.y_screen_v0 = y_scr[0];
    assign bus.y_screen_v1 = y_scr[1];
    assign bus.y_screen_v2 = y_scr[2];
    assign bus.y_screen_v3 = y_scr[3];
    assign bus.e0_init_t1 = e_out[0][0];
    assign bus.e1_init_t1 = e_out[0][1];
    assign bus.e2_init_t1 = e_out[0][2];
    assign bus.e0_init_t2 = e_out[1][0];
    assign bus.e1_init_t2 = e_out[1][1];
    assign bus.e2_init_t2 = e_out[1][2];
    assign bus.bar_iy = biy[0];
    assign bus.bar_iz = biz[0];
    assign bus.bar_iy_dx = bdy[0];
    assign bus.bar_iz_dx = bdz[0];
    assign bus.bar2_iy = biy[1];
    assign bus.bar2_iz = biz[1];
    assign bus.bar2_iy_dx = bdy[1];
    assign bus.bar2_iz_dx = bdz[1];
endmodule
